snn_output_accumulator: RTL and testbench

- Output-layer integration stage of the SNN; sits directly upstream of the arg-max classifier.
- Accepts weighted spike events from the hidden layer and integrates one signed membrane potential per class over NUM_STEPS timesteps, with an optional per-step leak.
- When the last timestep ends, it freezes the potential vector and drives a level start to the arg-max stage until that stage pulses done.
- It then clears its accumulators, reports completion and returns to idle.

---
 rtl/snn_pkg.sv | 30 +++
 rtl/snn_sat_accum_lane.sv | 42 ++++
 rtl/snn_output_accumulator.sv | 130 +++++++++++++
 tb/tb_snn_output_accumulator.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN output stage: FSM encoding,
// saturation bounds and flat-vector lane slicing.
`ifndef SNN_PKG_SV
`define SNN_PKG_SV

`define SNN_SLICE(vec, idx, w) vec[((idx)+1)*(w)-1 -: (w)]

package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ACCUM     = 2'b01,
    ST_WAIT_DONE = 2'b10
  } state_t;

  localparam int unsigned SAT_CALC_W = 128;

  // Largest value representable in a w-bit two's complement word.
  function automatic logic signed [SAT_CALC_W-1:0] sat_max(input int unsigned w);
    return $signed((SAT_CALC_W'(1) << (w - 1)) - SAT_CALC_W'(1));
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic logic signed [SAT_CALC_W-1:0] sat_min(input int unsigned w);
    return $signed(-(SAT_CALC_W'(1) << (w - 1)));
  endfunction

endpackage

`endif

// File: rtl/snn_sat_accum_lane.sv
// One class lane: saturating add of a signed weight, then optional
// step-end leak p - (p >>> LEAK_SHIFT). Purely combinational.
module snn_sat_accum_lane
  import snn_pkg::*;
#(
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned W_W        = 16,
  parameter int unsigned LEAK_SHIFT = 0
) (
  input  logic signed [DATA_W-1:0] i_pot,
  input  logic signed [W_W-1:0]    i_weight,
  input  logic                     i_spike,
  input  logic                     i_step_end,
  output logic signed [DATA_W-1:0] o_pot_c,
  output logic                     o_clip_c
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic signed [SUM_W-1:0]  sum_c;
  logic signed [DATA_W-1:0] acc_c;

  always_comb begin
    sum_c    = SUM_W'(i_pot) + SUM_W'(i_weight);
    acc_c    = i_pot;
    o_clip_c = 1'b0;
    if (i_spike) begin
      // One guard bit: a mismatch between the top two bits means overflow.
      if (sum_c[SUM_W-1] != sum_c[SUM_W-2]) begin
        o_clip_c = 1'b1;
        acc_c    = sum_c[SUM_W-1] ? DATA_W'(sat_min(DATA_W)) : DATA_W'(sat_max(DATA_W));
      end else begin
        acc_c = sum_c[DATA_W-1:0];
      end
    end
    o_pot_c = acc_c;
    if (i_step_end && (LEAK_SHIFT != 0)) begin
      o_pot_c = acc_c - (acc_c >>> LEAK_SHIFT);
    end
  end

endmodule

// File: rtl/snn_output_accumulator.sv
// Output-layer integrator: accumulates per-class potentials over NUM_STEPS
// timesteps, then holds them while handshaking with the arg-max stage.
module snn_output_accumulator
  import snn_pkg::*;
#(
  parameter int unsigned VEC_LEN    = 3,
  parameter int unsigned DATA_W     = 48,
  parameter int unsigned W_W        = 16,
  parameter int unsigned NUM_STEPS  = 4,
  parameter int unsigned LEAK_SHIFT = 0,
  localparam int unsigned CNT_W     = $clog2(NUM_STEPS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clk_enable,
  input  logic                        i_start,
  input  logic                        i_spike_valid,
  input  logic [VEC_LEN*W_W-1:0]      i_weights_flat,
  input  logic                        i_step_end,
  output logic                        o_in_ready,
  output logic [VEC_LEN*DATA_W-1:0]   o_potentials_flat,
  output logic                        o_argmax_start,
  input  logic                        i_argmax_done,
  output logic [CNT_W-1:0]            o_step_count,
  output logic                        o_saturated,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int unsigned POT_W = VEC_LEN * DATA_W;

  state_t             state_q, state_d;
  logic [POT_W-1:0]   pot_q, pot_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               sat_q, sat_d;
  logic               done_q, done_d;
  logic               start_q, start_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic [POT_W-1:0]   lane_pot_c;
  logic [VEC_LEN-1:0] lane_clip_c;

  for (genvar g = 0; g < VEC_LEN; g++) begin : g_lane
    snn_sat_accum_lane #(
      .DATA_W     (DATA_W),
      .W_W        (W_W),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .i_pot      (`SNN_SLICE(pot_q, g, DATA_W)),
      .i_weight   (`SNN_SLICE(i_weights_flat, g, W_W)),
      .i_spike    (i_spike_valid),
      .i_step_end (i_step_end),
      .o_pot_c    (`SNN_SLICE(lane_pot_c, g, DATA_W)),
      .o_clip_c   (lane_clip_c[g])
    );
  end

  always_comb begin
    state_d = state_q;
    pot_d   = pot_q;
    step_d  = step_q;
    sat_d   = sat_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_ACCUM;
          pot_d   = '0;
          step_d  = '0;
          sat_d   = 1'b0;
        end
      end
      ST_ACCUM: begin
        // Lanes pass potentials through unchanged when neither input is active.
        pot_d = lane_pot_c;
        sat_d = sat_q | (|lane_clip_c);
        if (i_step_end) begin
          step_d = step_q + CNT_W'(1);
          if (step_q == CNT_W'(NUM_STEPS - 1)) begin
            state_d = ST_WAIT_DONE;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (i_argmax_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          pot_d   = '0;
          step_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    start_d = (state_d == ST_WAIT_DONE);
    ready_d = (state_d == ST_ACCUM);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pot_q   <= '0;
      step_q  <= '0;
      sat_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (i_clk_enable) begin
      state_q <= state_d;
      pot_q   <= pot_d;
      step_q  <= step_d;
      sat_q   <= sat_d;
      done_q  <= done_d;
      start_q <= start_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign o_potentials_flat = pot_q;
  assign o_step_count      = step_q;
  assign o_saturated       = sat_q;
  assign o_done            = done_q;
  assign o_argmax_start    = start_q;
  assign o_in_ready        = ready_q;
  assign o_busy            = busy_q;

endmodule

// File: tb/tb_snn_output_accumulator.sv
// Directed bench: default, narrow-saturating and leaky instances share one
// stimulus stream; each scenario checks the instance it targets.
module tb_snn_output_accumulator;

  logic        clk, rst, en;
  logic        start, spike, step_end, amax_done;
  logic [47:0] weights;

  logic [143:0] d_pot;  logic [2:0] d_cnt;
  logic d_ready, d_astart, d_sat, d_busy, d_done;
  logic [47:0]  s_pot;  logic [2:0] s_cnt;
  logic s_ready, s_astart, s_sat, s_busy, s_done;
  logic [143:0] l_pot;  logic [2:0] l_cnt;
  logic l_ready, l_astart, l_sat, l_busy, l_done;

  int n_tests = 0;
  int n_fail  = 0;

  snn_output_accumulator u_dut (
    .clk(clk), .rst(rst), .i_clk_enable(en), .i_start(start),
    .i_spike_valid(spike), .i_weights_flat(weights), .i_step_end(step_end),
    .o_in_ready(d_ready), .o_potentials_flat(d_pot), .o_argmax_start(d_astart),
    .i_argmax_done(amax_done), .o_step_count(d_cnt), .o_saturated(d_sat),
    .o_busy(d_busy), .o_done(d_done));

  snn_output_accumulator #(.DATA_W(16), .W_W(16)) u_sat (
    .clk(clk), .rst(rst), .i_clk_enable(en), .i_start(start),
    .i_spike_valid(spike), .i_weights_flat(weights), .i_step_end(step_end),
    .o_in_ready(s_ready), .o_potentials_flat(s_pot), .o_argmax_start(s_astart),
    .i_argmax_done(amax_done), .o_step_count(s_cnt), .o_saturated(s_sat),
    .o_busy(s_busy), .o_done(s_done));

  snn_output_accumulator #(.LEAK_SHIFT(1)) u_leak (
    .clk(clk), .rst(rst), .i_clk_enable(en), .i_start(start),
    .i_spike_valid(spike), .i_weights_flat(weights), .i_step_end(step_end),
    .o_in_ready(l_ready), .o_potentials_flat(l_pot), .o_argmax_start(l_astart),
    .i_argmax_done(amax_done), .o_step_count(l_cnt), .o_saturated(l_sat),
    .o_busy(l_busy), .o_done(l_done));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint p48(input logic [143:0] v, input int c);
    logic signed [47:0] t;
    t = v[c*48 +: 48];
    return longint'(t);
  endfunction

  function automatic longint p16(input logic [47:0] v, input int c);
    logic signed [15:0] t;
    t = v[c*16 +: 16];
    return longint'(t);
  endfunction

  function automatic logic [47:0] wvec(input int c0, input int c1, input int c2);
    return {16'(c2), 16'(c1), 16'(c0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; spike = 1'b0;
    step_end = 1'b0; amax_done = 1'b0; weights = '0;
    @(negedge clk);
    check("rst_pot", longint'(d_pot), 0);
    check("rst_cnt", longint'(d_cnt), 0);
    check("rst_flags", longint'({d_ready, d_astart, d_sat, d_busy, d_done}), 0);
    rst = 1'b0;
    tick();

    // done in IDLE is ignored
    amax_done = 1'b1; tick(); amax_done = 1'b0;
    check("idle_done_ignored", longint'(d_done), 0);
    check("idle_busy", longint'(d_busy), 0);

    start = 1'b1; tick(); start = 1'b0;
    check("start_ready", longint'(d_ready), 1);
    check("start_busy", longint'(d_busy), 1);

    // basic integration, with a gated window in step 2
    for (int s = 0; s < 4; s++) begin
      if (s == 2) begin
        en = 1'b0; spike = 1'b1; weights = wvec(10, -5, 20);
        repeat (5) tick();
        check("gate_c0", p48(d_pot, 0), 20);
        check("gate_cnt", longint'(d_cnt), 2);
        en = 1'b1; spike = 1'b0;
      end
      spike = 1'b1; weights = wvec(10, -5, 20); tick(); spike = 1'b0;
      step_end = 1'b1; tick(); step_end = 1'b0;
      if (s < 3) begin
        check($sformatf("step%0d_cnt", s), longint'(d_cnt), longint'(s + 1));
        check($sformatf("step%0d_astart", s), longint'(d_astart), 0);
      end
    end
    check("int_astart", longint'(d_astart), 1);
    check("int_ready", longint'(d_ready), 0);
    check("int_cnt", longint'(d_cnt), 4);
    check("int_c0", p48(d_pot, 0), 40);
    check("int_c1", p48(d_pot, 1), -20);
    check("int_c2", p48(d_pot, 2), 80);

    // WAIT_DONE: inputs ignored, start held, enable dropped mid-way
    spike = 1'b1; start = 1'b1; step_end = 1'b1; weights = wvec(7, 7, 7);
    for (int i = 0; i < 10; i++) begin
      en = !(i >= 4 && i < 7);
      tick();
      check($sformatf("wait%0d_astart", i), longint'(d_astart), 1);
      check($sformatf("wait%0d_c1", i), p48(d_pot, 1), -20);
    end
    en = 1'b1; spike = 1'b0; start = 1'b0; step_end = 1'b0;
    check("wait_cnt", longint'(d_cnt), 4);
    amax_done = 1'b1; tick(); amax_done = 1'b0;
    check("done_pulse", longint'(d_done), 1);
    check("done_pot", longint'(d_pot), 0);
    check("done_busy", longint'(d_busy), 0);
    check("done_astart", longint'(d_astart), 0);
    check("done_cnt", longint'(d_cnt), 0);
    tick();
    check("done_one_cycle", longint'(d_done), 0);

    // saturation on the 16-bit instance
    start = 1'b1; tick(); start = 1'b0;
    spike = 1'b1; weights = wvec(30000, 0, 0);
    tick();
    check("sat_first", p16(s_pot, 0), 30000);
    check("sat_flag_clear", longint'(s_sat), 0);
    tick();
    check("sat_clip", p16(s_pot, 0), 32767);
    check("sat_flag", longint'(s_sat), 1);
    tick();
    check("sat_hold_max", p16(s_pot, 0), 32767);
    check("wide_no_clip", p48(d_pot, 0), 90000);
    spike = 1'b0;
    step_end = 1'b1; repeat (4) tick(); step_end = 1'b0;
    check("sat_astart", longint'(s_astart), 1);
    amax_done = 1'b1; tick(); amax_done = 1'b0;
    check("sat_sticky_idle", longint'(s_sat), 1);
    check("sat_done", longint'(s_done), 1);
    check("wide_sat_flag", longint'(d_sat), 0);
    start = 1'b1; tick(); start = 1'b0;
    check("sat_cleared_on_start", longint'(s_sat), 0);

    // leak with simultaneous spike and step_end
    spike = 1'b1; weights = wvec(0, 100, 0); tick();
    check("leak_pre", p48(l_pot, 1), 100);
    weights = wvec(0, 20, 0); step_end = 1'b1; tick();
    spike = 1'b0; step_end = 1'b0;
    check("leak_c1", p48(l_pot, 1), 60);
    check("noleak_c1", p48(d_pot, 1), 120);
    check("leak_cnt", longint'(l_cnt), 1);

    // asynchronous reset mid-ACCUM
    rst = 1'b1; #1;
    check("arst_busy", longint'(d_busy), 0);
    check("arst_ready", longint'(d_ready), 0);
    check("arst_pot", longint'(d_pot), 0);
    check("arst_cnt", longint'(d_cnt), 0);
    check("arst_leak_pot", longint'(l_pot), 0);
    @(negedge clk); rst = 1'b0; tick();
    check("post_rst_busy", longint'(d_busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
